// File: rtl/regfile_bypass_32x32_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the Lab 4 CPU architectural register file.
//   NUM_REGS   : number of architectural registers
//   REG_ADDR_W : register index width
//   ZERO_REG   : index that always reads zero and discards writes
// ----------------------------------------------------------------------------
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

endpackage : regfile_pkg

// File: rtl/regfile_bypass_32x32_if.sv
// ----------------------------------------------------------------------------
// regfile_bypass_32x32_if
//   Groups the register-file write port (WB stage) and the two read ports
//   (ID stage).
//   master : pipeline side, drives write/read requests, receives read data
//   slave  : register file side
//   Signals:
//     RegWrite       write enable
//     WriteRegister  destination index
//     WriteData      data to commit
//     ReadRegister1  port A source index
//     ReadRegister2  port B source index
//     ReadData1      port A data (combinational)
//     ReadData2      port B data (combinational)
// ----------------------------------------------------------------------------
interface regfile_bypass_32x32_if #(
  parameter int WIDTH = 32
) ();

  import regfile_pkg::*;

  logic             RegWrite;
  reg_addr_t        WriteRegister;
  logic [WIDTH-1:0] WriteData;
  reg_addr_t        ReadRegister1;
  reg_addr_t        ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite,
    output WriteRegister,
    output WriteData,
    output ReadRegister1,
    output ReadRegister2,
    input  ReadData1,
    input  ReadData2
  );

  modport slave (
    input  RegWrite,
    input  WriteRegister,
    input  WriteData,
    input  ReadRegister1,
    input  ReadRegister2,
    output ReadData1,
    output ReadData2
  );

endinterface : regfile_bypass_32x32_if

// File: rtl/regfile_bypass_32x32_decoder.sv
// ----------------------------------------------------------------------------
// decoder_5_32
//   One-hot write decoder for the register file. Produces the per-register
//   write enables.
//   en     : write enable (RegWrite qualified by reset)
//   addr   : destination register index
//   onehot : per-register enable, at most one bit set; never sets ZERO_REG
// ----------------------------------------------------------------------------
module decoder_5_32
  import regfile_pkg::*;
(
  input  logic                en,
  input  reg_addr_t           addr,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise a latch is inferred.
    onehot = '0;
    if (en && (addr != ZERO_ADDR)) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule : decoder_5_32

// File: rtl/regfile_bypass_32x32.sv
// ----------------------------------------------------------------------------
// regfile_bypass_32x32
//   Architectural register file: 32 x WIDTH, one write port (WB), two
//   combinational read ports (ID) with write-through bypass so an ID read
//   sees the value WB is writing in the same cycle. Register ZERO_REG is
//   hardwired to zero.
//   Ports:
//     clk    : system clock, state changes on posedge
//     reset  : asynchronous active-low reset, clears all registers
//     bus    : write/read port bundle (slave side)
// ----------------------------------------------------------------------------
module regfile_bypass_32x32
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_bypass_32x32_if.slave  bus
);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;
  logic                wr_active;
  logic                bypass_a;
  logic                bypass_b;

  // A write is only live while reset is released; this also disables the
  // bypass during reset.
  assign wr_active = bus.RegWrite && reset;

  decoder_5_32 u_decoder (
    .en     (wr_active),
    .addr   (bus.WriteRegister),
    .onehot (wr_en)
  );

  // NOTE: the whole array is cleared by the async reset. This is deliberate:
  // the architectural state must read zero out of reset, so the storage is
  // built from resettable flops rather than an inferred RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en[i]) begin
          regs[i] <= bus.WriteData;
        end
      end
    end
  end

  // Bypass when WB targets the same non-zero register this cycle.
  assign bypass_a = wr_active && (bus.WriteRegister == bus.ReadRegister1) &&
                    (bus.WriteRegister != ZERO_ADDR);
  assign bypass_b = wr_active && (bus.WriteRegister == bus.ReadRegister2) &&
                    (bus.WriteRegister != ZERO_ADDR);

  always_comb begin
    bus.ReadData1 = '0;
    if (reset && (bus.ReadRegister1 != ZERO_ADDR)) begin
      bus.ReadData1 = bypass_a ? bus.WriteData : regs[bus.ReadRegister1];
    end
  end

  always_comb begin
    bus.ReadData2 = '0;
    if (reset && (bus.ReadRegister2 != ZERO_ADDR)) begin
      bus.ReadData2 = bypass_b ? bus.WriteData : regs[bus.ReadRegister2];
    end
  end

endmodule : regfile_bypass_32x32

// File: tb/tb_regfile_bypass_32x32.sv
// ----------------------------------------------------------------------------
// tb_regfile_bypass_32x32
//   Directed self-checking bench for regfile_bypass_32x32. Inputs change on
//   the falling edge; outputs are sampled 1 time unit after a change or after
//   the rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_bypass_32x32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_bypass_32x32_if #(.WIDTH(32)) bus_if ();

  regfile_bypass_32x32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write one register: inputs set on negedge, committed on posedge.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_if.RegWrite      = 1'b1;
    bus_if.WriteRegister = addr;
    bus_if.WriteData     = data;
    @(posedge clk);
    #1;
    bus_if.RegWrite      = 1'b0;
  endtask

  task automatic test_reset();
    reset                = 1'b0;
    bus_if.RegWrite      = 1'b1;
    bus_if.WriteRegister = 5'd5;
    bus_if.WriteData     = 32'hDEADBEEF;
    bus_if.ReadRegister1 = 5'd5;
    bus_if.ReadRegister2 = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd1_x5: got %h expected %h", bus_if.ReadData1, 32'h0);
    end
    checks++;
    if (bus_if.ReadData2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd2_x5: got %h expected %h", bus_if.ReadData2, 32'h0);
    end
    @(negedge clk);
    reset           = 1'b1;
    bus_if.RegWrite = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      bus_if.ReadRegister1 = 5'(i);
      bus_if.ReadRegister2 = 5'(31 - i);
      #1;
      checks++;
      if (bus_if.ReadData1 !== 32'h0 || bus_if.ReadData2 !== 32'h0) begin
        errors++;
        $display("FAIL post_reset_x%0d: got %h/%h expected 0/0", i,
                 bus_if.ReadData1, bus_if.ReadData2);
      end
    end
  endtask

  task automatic test_basic();
    do_write(5'd3, 32'h00000002);
    do_write(5'd4, 32'h00000005);
    @(negedge clk);
    bus_if.ReadRegister1 = 5'd3;
    bus_if.ReadRegister2 = 5'd4;
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h2) begin
      errors++;
      $display("FAIL basic_x3: got %h expected %h", bus_if.ReadData1, 32'h2);
    end
    checks++;
    if (bus_if.ReadData2 !== 32'h5) begin
      errors++;
      $display("FAIL basic_x4: got %h expected %h", bus_if.ReadData2, 32'h5);
    end
    // RegWrite low: the presented write must be ignored.
    bus_if.RegWrite      = 1'b0;
    bus_if.WriteRegister = 5'd3;
    bus_if.WriteData     = 32'h1;
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h2) begin
      errors++;
      $display("FAIL no_we_bypass_x3: got %h expected %h", bus_if.ReadData1, 32'h2);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h2) begin
      errors++;
      $display("FAIL no_we_hold_x3: got %h expected %h", bus_if.ReadData1, 32'h2);
    end
  endtask

  task automatic test_bypass();
    do_write(5'd7, 32'h11);
    @(negedge clk);
    bus_if.ReadRegister1 = 5'd7;
    bus_if.ReadRegister2 = 5'd7;
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h11) begin
      errors++;
      $display("FAIL bypass_pre_x7: got %h expected %h", bus_if.ReadData1, 32'h11);
    end
    bus_if.RegWrite      = 1'b1;
    bus_if.WriteRegister = 5'd7;
    bus_if.WriteData     = 32'hAA;
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'hAA || bus_if.ReadData2 !== 32'hAA) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h/%h expected aa/aa",
               bus_if.ReadData1, bus_if.ReadData2);
    end
    @(posedge clk);
    #1;
    bus_if.RegWrite = 1'b0;
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'hAA || bus_if.ReadData2 !== 32'hAA) begin
      errors++;
      $display("FAIL bypass_after_edge: got %h/%h expected aa/aa",
               bus_if.ReadData1, bus_if.ReadData2);
    end
    // Bypass on one port only: port B reads a different register.
    @(negedge clk);
    bus_if.RegWrite      = 1'b1;
    bus_if.WriteRegister = 5'd3;
    bus_if.WriteData     = 32'h77;
    bus_if.ReadRegister1 = 5'd3;
    bus_if.ReadRegister2 = 5'd7;
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h77 || bus_if.ReadData2 !== 32'hAA) begin
      errors++;
      $display("FAIL bypass_port_a_only: got %h/%h expected 77/aa",
               bus_if.ReadData1, bus_if.ReadData2);
    end
    @(posedge clk);
    #1;
    bus_if.RegWrite = 1'b0;
  endtask

  task automatic test_zero();
    @(negedge clk);
    bus_if.RegWrite      = 1'b1;
    bus_if.WriteRegister = 5'd31;
    bus_if.WriteData     = 32'hFFFFFFFF;
    bus_if.ReadRegister1 = 5'd31;
    bus_if.ReadRegister2 = 5'd31;
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h0 || bus_if.ReadData2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_no_bypass: got %h/%h expected 0/0",
               bus_if.ReadData1, bus_if.ReadData2);
    end
    @(posedge clk);
    #1;
    bus_if.RegWrite = 1'b0;
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h0 || bus_if.ReadData2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_after_edge: got %h/%h expected 0/0",
               bus_if.ReadData1, bus_if.ReadData2);
    end
  endtask

  task automatic test_async_reset();
    do_write(5'd10, 32'h1234);
    @(negedge clk);
    bus_if.ReadRegister1 = 5'd10;
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h1234) begin
      errors++;
      $display("FAIL async_pre_x10: got %h expected %h", bus_if.ReadData1, 32'h1234);
    end
    // Drop reset between edges with a write pending to X10.
    bus_if.RegWrite      = 1'b1;
    bus_if.WriteRegister = 5'd10;
    bus_if.WriteData     = 32'h5555;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h0) begin
      errors++;
      $display("FAIL async_immediate_x10: got %h expected %h", bus_if.ReadData1, 32'h0);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    reset           = 1'b1;
    bus_if.RegWrite = 1'b0;
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h0) begin
      errors++;
      $display("FAIL async_release_x10: got %h expected %h", bus_if.ReadData1, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h0) begin
      errors++;
      $display("FAIL async_hold_x10: got %h expected %h", bus_if.ReadData1, 32'h0);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    for (int i = 0; i < 31; i++) begin
      do_write(5'(i), 32'(i) * 32'h01010101);
    end
    @(negedge clk);
    for (int i = 0; i < 31; i++) begin
      bus_if.ReadRegister1 = 5'(i);
      bus_if.ReadRegister2 = 5'(30 - i);
      exp_a = 32'(i) * 32'h01010101;
      exp_b = 32'(30 - i) * 32'h01010101;
      #1;
      checks++;
      if (bus_if.ReadData1 !== exp_a || bus_if.ReadData2 !== exp_b) begin
        errors++;
        $display("FAIL sweep_pair_%0d: got %h/%h expected %h/%h", i,
                 bus_if.ReadData1, bus_if.ReadData2, exp_a, exp_b);
      end
    end
    bus_if.ReadRegister1 = 5'd31;
    bus_if.ReadRegister2 = 5'd31;
    #1;
    checks++;
    if (bus_if.ReadData1 !== 32'h0 || bus_if.ReadData2 !== 32'h0) begin
      errors++;
      $display("FAIL sweep_x31: got %h/%h expected 0/0",
               bus_if.ReadData1, bus_if.ReadData2);
    end
  endtask

  initial begin
    checks               = 0;
    errors               = 0;
    reset                = 1'b0;
    bus_if.RegWrite      = 1'b0;
    bus_if.WriteRegister = '0;
    bus_if.WriteData     = '0;
    bus_if.ReadRegister1 = '0;
    bus_if.ReadRegister2 = '0;
    test_reset();
    test_basic();
    test_bypass();
    test_zero();
    test_async_reset();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile_bypass_32x32

// File: doc/regfile_bypass_32x32.md
Name: regfile_bypass_32x32

Overview:
- Architectural register file for the Lab 4 pipelined CPU: 32 registers × WIDTH bits, one write port (WB stage), two read ports (ID stage).
- It is the read end of the register-write path. Writes commit on the rising clock edge; reads are combinational.
- Internal write-through bypass lets an ID-stage read see the value WB is writing in the same cycle.
- X31 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register and of every data port (must be > 0).
- NUM_REGS, 32, register count; address width is log2(NUM_REGS) = 5.
- ZERO_REG, 31, index that always reads 0 and ignores writes.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset; clears all registers.
- RegWrite  input  1  write enable for the write port.
- WriteRegister  input  5  destination register index.
- WriteData  input  WIDTH  data to write.
- ReadRegister1  input  5  source index, port A.
- ReadRegister2  input  5  source index, port B.
- ReadData1  output  WIDTH  port A data (combinational).
- ReadData2  output  WIDTH  port B data (combinational).

Behaviour:
- Reset:
  - reset low clears all storage to 0 immediately, independent of clk.
  - While reset is low, ReadData1 and ReadData2 are 0 and the bypass is disabled.
  - Writes are ignored until the first posedge after reset goes high.
- Write:
  - On posedge clk with reset high, RegWrite=1 and WriteRegister != ZERO_REG, storage[WriteRegister] <= WriteData.
  - Exactly one register updates; all others hold.
  - RegWrite=0: no register changes.
- Zero register:
  - Writes to index 31 are discarded.
  - Reads of index 31 return 0 on both ports at all times, including the bypass case.
- Read:
  - ReadDataN = storage[ReadRegisterN], combinational, zero-cycle latency from the address.
- Bypass:
  - Condition: RegWrite=1, reset high, WriteRegister == ReadRegisterN, WriteRegister != ZERO_REG.
  - When true, ReadDataN = WriteData in the same cycle, before the edge.
  - After the edge the stored value matches, so output is continuous.
- Both ports may name the same register; both bypass independently and return identical data.
- Reset asserted mid-cycle with a write pending: the reset wins; no write occurs at that edge.
- Address inputs are always in range (5 bits, 32 entries); there is no error signalling.
- Storage lives in a single `always_ff @(posedge clk or negedge reset)`. Read/bypass logic is purely combinational (`always_comb`).

Decomposition:
- Package regfile_pkg:
  - localparams NUM_REGS=32, REG_ADDR_W=5, ZERO_REG=31.
  - typedef logic [REG_ADDR_W-1:0] reg_addr_t.
- One sub-module: decoder_5_32. It is a 5-to-32 one-hot write decoder gated by RegWrite and forced 0 at ZERO_REG. Its output drives the per-register enables.
- Read muxes and bypass comparators stay inline.

Test Plan:
- Reset: hold reset=0 for 3 cycles with RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF -> ReadData1 for X5 = 0. After release with RegWrite=0, X0..X31 all read 0.
- Basic write/read: write X3=0x00000002, then X4=0x00000005 on consecutive edges -> next cycle ReadRegister1=3 gives 0x2 and ReadRegister2=4 gives 0x5. A write of X3=0x1 with RegWrite=0 leaves X3=0x2.
- Bypass: with X7=0x11, in one cycle set RegWrite=1, WriteRegister=7, WriteData=0xAA, ReadRegister1=ReadRegister2=7 -> both ports read 0xAA before the edge and 0xAA after.
- Zero register: write X31=0xFFFFFFFF with RegWrite=1 -> ReadData1 for X31 = 0 in the write cycle (no bypass) and after the edge.
- Async reset mid-operation: load X10=0x1234, then drop reset between clock edges -> ReadData1 for X10 goes to 0 immediately, before the next posedge. After release, X10 stays 0.
- Sweep: write Xi = i·0x01010101 for i=0..30, then read all pairs (i, 30−i) -> every value matches, and X31 = 0.
